// File: rtl/ascon_bdo_serializer_pkg.sv
// Shared types, widths and helpers for the ASCON output-side width converter.
package ascon_bdo_serializer_pkg;

   localparam int unsigned BLK_W  = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned NWORDS = BLK_W / WORD_W;

   typedef enum logic [1:0] {D_NULL, D_AD, D_MSG, D_TAG} e_data_type;

   typedef enum logic {S_IDLE, S_DRAIN} e_state;

   // Highest set bit index + 1; 0 for an empty mask.
   function automatic logic [2:0] f_word_count(input logic [NWORDS-1:0] mask);
      f_word_count = 3'd0;
      for (int i = 0; i < NWORDS; i++) begin
         if (mask[i]) f_word_count = 3'(i + 1);
      end
   endfunction

endpackage

// File: rtl/ascon_bdo_serializer_if.sv
// Core-block input, word stream output and tag signals of the serializer.
interface ascon_bdo_serializer_if
   import ascon_bdo_serializer_pkg::*;
;
   logic [BLK_W-1:0]  bdo_i;
   logic              bdo_valid_i;
   logic              bdo_ready_o;
   logic [NWORDS-1:0] bdo_word_valid_i;
   e_data_type        bdo_type_i;
   logic              bdo_eot_i;
   logic [WORD_W-1:0] word_o;
   logic              word_valid_o;
   logic              word_ready_i;
   e_data_type        word_type_o;
   logic              word_last_o;
   logic [BLK_W-1:0]  tag_o;
   logic              tag_valid_o;
   logic              tag_clr_i;
   logic              tag_overrun_o;
   logic              flush_i;
   logic              busy_o;

   modport slave (
      input  bdo_i, bdo_valid_i, bdo_word_valid_i, bdo_type_i, bdo_eot_i,
      input  word_ready_i, tag_clr_i, flush_i,
      output bdo_ready_o, word_o, word_valid_o, word_type_o, word_last_o,
      output tag_o, tag_valid_o, tag_overrun_o, busy_o
   );

   modport master (
      output bdo_i, bdo_valid_i, bdo_word_valid_i, bdo_type_i, bdo_eot_i,
      output word_ready_i, tag_clr_i, flush_i,
      input  bdo_ready_o, word_o, word_valid_o, word_type_o, word_last_o,
      input  tag_o, tag_valid_o, tag_overrun_o, busy_o
   );

endinterface

// File: rtl/ascon_bdo_serializer.sv
// Splits 128-bit ASCON output blocks into 32-bit words, LSW first; tag blocks
// are diverted into a held tag register.
module ascon_bdo_serializer
   import ascon_bdo_serializer_pkg::*;
(
   input logic                    clk_i,
   input logic                    rst_ni,
   ascon_bdo_serializer_if.slave  bus
);

   e_state           r_state, w_state_d;
   logic [1:0]       r_idx, w_idx_d;
   logic [1:0]       r_cnt;
   logic [BLK_W-1:0] r_buf;
   e_data_type       r_type;
   logic             r_eot;
   logic [BLK_W-1:0] r_tag;
   logic             r_tag_valid;
   logic             r_tag_ovr;

   logic       w_valid, w_word_hs, w_last, w_bdo_ready, w_accept, w_is_tag, w_data_load;
   logic [2:0] w_wcount;

   assign w_valid     = (r_state == S_DRAIN);
   assign w_word_hs   = w_valid && bus.word_ready_i;
   assign w_last      = (r_idx == r_cnt);
   // word_ready_i -> bdo_ready_o is combinational so the next block loads with no bubble.
   assign w_bdo_ready = !bus.flush_i && (!w_valid || (w_word_hs && w_last));
   assign w_accept    = bus.bdo_valid_i && w_bdo_ready;
   assign w_is_tag    = (bus.bdo_type_i == D_TAG);
   assign w_wcount    = f_word_count(bus.bdo_word_valid_i);
   assign w_data_load = w_accept && !w_is_tag && (w_wcount != 3'd0);

   always_comb begin
      w_state_d = r_state;
      w_idx_d   = r_idx;
      if (bus.flush_i) begin
         w_state_d = S_IDLE;
         w_idx_d   = 2'd0;
      end else if (w_data_load) begin
         w_state_d = S_DRAIN;
         w_idx_d   = 2'd0;
      end else if (w_word_hs) begin
         if (w_last) w_state_d = S_IDLE;
         else        w_idx_d   = r_idx + 2'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_idx   <= 2'd0;
      end else begin
         r_state <= w_state_d;
         r_idx   <= w_idx_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_buf  <= '0;
         r_cnt  <= 2'd0;
         r_type <= D_NULL;
         r_eot  <= 1'b0;
      end else if (w_data_load) begin
         r_buf  <= bus.bdo_i;
         r_cnt  <= 2'(w_wcount - 3'd1);
         r_type <= bus.bdo_type_i;
         r_eot  <= bus.bdo_eot_i;
      end
   end

   // A capture beats a same-cycle clear; only flush or reset drop the overrun flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tag       <= '0;
         r_tag_valid <= 1'b0;
         r_tag_ovr   <= 1'b0;
      end else if (bus.flush_i) begin
         r_tag_valid <= 1'b0;
         r_tag_ovr   <= 1'b0;
      end else if (w_accept && w_is_tag) begin
         r_tag       <= bus.bdo_i;
         r_tag_valid <= 1'b1;
         if (r_tag_valid) r_tag_ovr <= 1'b1;
      end else if (bus.tag_clr_i) begin
         r_tag_valid <= 1'b0;
      end
   end

   assign bus.bdo_ready_o   = w_bdo_ready;
   assign bus.word_valid_o  = w_valid;
   assign bus.word_o        = w_valid ? r_buf[{r_idx, 5'd0} +: WORD_W] : '0;
   assign bus.word_type_o   = w_valid ? r_type : D_NULL;
   assign bus.word_last_o   = w_valid && r_eot && w_last;
   assign bus.tag_o         = r_tag;
   assign bus.tag_valid_o   = r_tag_valid;
   assign bus.tag_overrun_o = r_tag_ovr;
   assign bus.busy_o        = (r_state != S_IDLE);

endmodule
